// File: rtl/qei_velocity_if.sv
// Bundle between the quadrature decoder (step strobe, direction, enable) and the
// velocity/period estimator outputs.
interface qei_velocity_if #(
    parameter int VEL_W = 16,
    parameter int PER_W = 16
);
    logic                    ena;
    logic                    step;
    logic                    dir;
    logic signed [VEL_W-1:0] velocity;
    logic                    vel_sat;
    logic                    vel_valid;
    logic        [PER_W-1:0] period;
    logic                    per_valid;
    logic                    stalled;

    modport master (
        output ena, step, dir,
        input  velocity, vel_sat, vel_valid, period, per_valid, stalled
    );

    modport slave (
        input  ena, step, dir,
        output velocity, vel_sat, vel_valid, period, per_valid, stalled
    );
endinterface

// File: rtl/qei_velocity.sv
// Gate-window velocity estimator for quadrature steps, with an optional inter-step
// period meter and stall detector built only when QEI_VEL_PERIOD_EN is defined.
module qei_velocity #(
    parameter int GATE_CYCLES = 100000,
    parameter int VEL_W       = 16,
    parameter int PER_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    qei_velocity_if.slave   bus
);
    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [VEL_W-1:0] VEL_ONE = {{(VEL_W-1){1'b0}}, 1'b1};

    logic [TW-1:0]           timer;
    logic signed [VEL_W-1:0] acc;
    logic signed [VEL_W-1:0] acc_upd;
    logic                    sticky;
    logic                    clamp;
    logic                    step_en;
    logic                    terminal;
    logic signed [VEL_W-1:0] velocity_q;
    logic                    vel_sat_q;
    logic                    vel_valid_q;

    // A clamped update leaves the accumulator at the rail and flags the window.
    always_comb begin
        step_en  = bus.ena & bus.step;
        terminal = bus.ena && (timer == TIMER_LAST);
        acc_upd  = acc;
        clamp    = 1'b0;
        if (step_en) begin
            if (bus.dir) begin
                if (acc == VEL_MAX) clamp = 1'b1;
                else                acc_upd = acc + VEL_ONE;
            end else begin
                if (acc == VEL_MIN) clamp = 1'b1;
                else                acc_upd = acc - VEL_ONE;
            end
        end
    end

    // The terminal-cycle step is folded into the closing window before the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            acc         <= '0;
            sticky      <= 1'b0;
            velocity_q  <= '0;
            vel_sat_q   <= 1'b0;
            vel_valid_q <= 1'b0;
        end else begin
            vel_valid_q <= 1'b0;
            if (bus.ena) begin
                if (terminal) begin
                    velocity_q  <= acc_upd;
                    vel_sat_q   <= sticky | clamp;
                    vel_valid_q <= 1'b1;
                    acc         <= '0;
                    sticky      <= 1'b0;
                    timer       <= '0;
                end else begin
                    acc    <= acc_upd;
                    sticky <= sticky | clamp;
                    timer  <= timer + 1'b1;
                end
            end
        end
    end

    assign bus.velocity  = velocity_q;
    assign bus.vel_sat   = vel_sat_q;
    assign bus.vel_valid = vel_valid_q;

`ifdef QEI_VEL_PERIOD_EN
    typedef enum logic {COUNTING, STALLED} per_state_t;

    localparam logic [PER_W-1:0] PER_ONES = '1;

    per_state_t       state;
    per_state_t       state_next;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] cnt_inc;
    logic [PER_W-1:0] period_q;
    logic             per_valid_q;
    logic             stalled_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COUNTING;
        else        state <= state_next;
    end

    // Counter starts at all-ones, so the first step after reset reports "unknown".
    always_comb begin
        cnt_inc    = (per_cnt == PER_ONES) ? PER_ONES : per_cnt + 1'b1;
        state_next = state;
        if (step_en)
            state_next = COUNTING;
        else if (bus.ena && state == COUNTING && cnt_inc == PER_ONES)
            state_next = STALLED;
    end

    always_comb begin
        stalled_o = (state == STALLED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt     <= PER_ONES;
            period_q    <= '0;
            per_valid_q <= 1'b0;
        end else begin
            per_valid_q <= 1'b0;
            if (bus.ena) begin
                if (step_en) begin
                    period_q    <= cnt_inc;
                    per_valid_q <= 1'b1;
                    per_cnt     <= '0;
                end else begin
                    per_cnt <= cnt_inc;
                end
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.per_valid = per_valid_q;
    assign bus.stalled   = stalled_o;
`else
    assign bus.period    = {PER_W{1'b0}};
    assign bus.per_valid = 1'b0;
    assign bus.stalled   = 1'b0;
`endif
endmodule

// File: tb/tb_qei_velocity.sv
// Scoreboarded bench for qei_velocity: directed scenarios plus randomized step traffic
// against a window/step-history reference model.
module tb_qei_velocity;
    localparam int GATE = 100;
    localparam int VW   = 6;
    localparam int PW   = 8;
    localparam int VMAX = 31;
    localparam int VMIN = -32;
    localparam int PMAX = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    qei_velocity_if #(.VEL_W(VW), .PER_W(PW)) bus();

    qei_velocity #(.GATE_CYCLES(GATE), .VEL_W(VW), .PER_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int due; int val; bit sat;} vel_exp_t;
    typedef struct {int due; int val;} per_exp_t;

    vel_exp_t vel_q[$];
    per_exp_t per_q[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: window sum with per-step clamping, and step history.
    int acc;
    bit sat;
    int win_cnt;
    int en_idx;
    int last_step;
    bit stalled_next;
    bit stalled_cur;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic model_reset();
        acc          = 0;
        sat          = 1'b0;
        win_cnt      = 0;
        last_step    = -100000;
        stalled_next = 1'b0;
        stalled_cur  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_output("rst_velocity", bus.velocity, 0);
        check_output("rst_vel_sat", bus.vel_sat, 0);
        check_output("rst_vel_valid", bus.vel_valid, 0);
        check_output("rst_period", bus.period, 0);
        check_output("rst_per_valid", bus.per_valid, 0);
        check_output("rst_stalled", bus.stalled, 0);
    endtask

    // Called just after a rising edge; drives one cycle and predicts its effects.
    task automatic apply_stimulus(input bit e, input bit s, input bit d);
        int gap;
        stalled_cur = stalled_next;
        bus.ena  = e;
        bus.step = s;
        bus.dir  = d;
        if (e) begin
            if (s) begin
                if (d) begin
                    if (acc == VMAX) sat = 1'b1;
                    else acc++;
                end else begin
                    if (acc == VMIN) sat = 1'b1;
                    else acc--;
                end
            end
            gap = en_idx - last_step;
            if (s) begin
`ifdef QEI_VEL_PERIOD_EN
                per_q.push_back('{cyc + 1, (gap > PMAX) ? PMAX : gap});
`endif
                last_step    = en_idx;
                stalled_next = 1'b0;
            end else begin
                stalled_next = (gap >= PMAX);
            end
            en_idx++;
            win_cnt++;
            if (win_cnt == GATE) begin
                vel_q.push_back('{cyc + 1, acc, sat});
                acc     = 0;
                sat     = 1'b0;
                win_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations when due and flags any unexpected strobe.
    always @(negedge clk) begin
        vel_exp_t ve;
        per_exp_t pe;
        if (rst_n) begin
            if (vel_q.size() > 0 && vel_q[0].due <= cyc) begin
                ve = vel_q.pop_front();
                check_output("vel_valid", bus.vel_valid, 1);
                if (bus.vel_valid) begin
                    check_output("velocity", bus.velocity, ve.val);
                    check_output("vel_sat", bus.vel_sat, ve.sat);
                end
            end else if (bus.vel_valid) begin
                check_output("vel_valid_spurious", 1, 0);
            end
`ifdef QEI_VEL_PERIOD_EN
            if (per_q.size() > 0 && per_q[0].due <= cyc) begin
                pe = per_q.pop_front();
                check_output("per_valid", bus.per_valid, 1);
                if (bus.per_valid) check_output("period", bus.period, pe.val);
            end else if (bus.per_valid) begin
                check_output("per_valid_spurious", 1, 0);
            end
            check_output("stalled", bus.stalled, stalled_cur);
`else
            pe = '{0, 0};
            check_output("period_tied", bus.period, pe.val);
            check_output("per_valid_tied", bus.per_valid, 0);
            check_output("stalled_tied", bus.stalled, 0);
`endif
        end
    end

    initial begin
        int p;
        int db;
        bus.ena  = 1'b0;
        bus.step = 1'b0;
        bus.dir  = 1'b0;
        en_idx   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        repeat (200) apply_stimulus(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) apply_stimulus(1'b1, i >= 20 && i < 30, 1'b1);

        for (int i = 0; i < 100; i++)
            apply_stimulus(1'b1, (i >= 10 && i < 17) || (i >= 40 && i < 43) || i == 99,
                           !(i >= 40 && i < 43));

        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 100; i++) apply_stimulus(1'b1, w != 1 && i < 40, w == 0);

        for (int i = 0; i < 130; i++) begin
            if (i >= 50 && i < 80) apply_stimulus(1'b0, i % 6 == 0, 1'b1);
            else apply_stimulus(1'b1, i % 10 == 5 && (i < 50 || i == 95), 1'b1);
        end

        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1);
            repeat (24) apply_stimulus(1'b1, 1'b0, 1'b0);
        end
        repeat (300) apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, i < 12, 1'b1);
        mid_reset();
        for (int i = 0; i < 100; i++) apply_stimulus(1'b1, i % 10 == 0, 1'b1);

        for (int seg = 0; seg < 30; seg++) begin
            p  = $urandom_range(0, 100);
            db = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++)
                apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 99) < p,
                               $urandom_range(0, 99) < db);
        end

        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("vel_queue_drained", vel_q.size(), 0);
        check_output("per_queue_drained", per_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/qei_velocity.md
# qei_velocity

Velocity and period estimator downstream of the quadrature decoder. Consumes the decoder's one-cycle count-step strobe and direction bit and produces a signed steps-per-gate-window velocity, with a saturation flag. It optionally produces an inter-step period measurement for low-speed use. It sits between the decoder core and the output mux feeding `uo_out`/`uio_out`.

## Interface
- `GATE_CYCLES`, default 100000: gate window length in `clk` cycles; must be ≥ 2.
- `VEL_W`, default 16: velocity width, two's complement.
- `PER_W`, default 16: period counter width; used only with `QEI_VEL_PERIOD_EN`.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  block enable; low = freeze.
- `step`  in  1  one-cycle pulse per decoded quadrature edge.
- `dir`  in  1  direction, sampled with `step`: 1 = +1, 0 = −1.
- `velocity`  out  `VEL_W`  signed step count of the last completed window.
- `vel_sat`  out  1  the last completed window saturated.
- `vel_valid`  out  1  one-cycle pulse when `velocity` updates.
- `period`  out  `PER_W`  cycles between the last two steps (`QEI_VEL_PERIOD_EN` only).
- `per_valid`  out  1  one-cycle pulse when `period` updates (`QEI_VEL_PERIOD_EN` only).
- `stalled`  out  1  no step for 2^`PER_W`−1 cycles (`QEI_VEL_PERIOD_EN` only).

## Operation
- Reset: gate timer = 0, accumulator = 0, sticky saturation = 0.
- Reset outputs: `velocity` = 0, `vel_sat` = 0, `vel_valid` = 0, `period` = 0, `per_valid` = 0, `stalled` = 0. The period counter resets to all-ones.
- Gate timer counts 0 … `GATE_CYCLES`−1 while `ena` = 1. The cycle where the timer is at `GATE_CYCLES`−1 is the terminal cycle.
- Each enabled cycle with `step` = 1 updates the accumulator by +1 or −1 according to `dir`.
- The update saturates at +2^(`VEL_W`−1)−1 and −2^(`VEL_W`−1). A clamped update sets the sticky saturation bit for the window.
- Terminal cycle:
  - `velocity` ← accumulator plus this cycle's step contribution, saturated.
  - `vel_sat` ← sticky bit, including this cycle's step.
  - `vel_valid` ← 1.
  - Accumulator ← 0, sticky bit ← 0, timer ← 0.
  - A step on the terminal cycle always counts in the closing window, never the next.
- `ena` = 0: timer, accumulator, sticky bit and period counter hold; `step` is ignored; `vel_valid` and `per_valid` stay 0; outputs hold their last values.
- Period FSM (with `QEI_VEL_PERIOD_EN`):
  - States: COUNTING, STALLED.
  - COUNTING: counter increments each enabled cycle and saturates at all-ones. Reaching all-ones moves to STALLED and sets `stalled` = 1.
  - STALLED: `stalled` stays 1.
  - Any enabled step, from either state: `period` ← counter + 1 (saturated), `per_valid` ← 1, counter ← 0, `stalled` ← 0, state ← COUNTING.
  - The first step after reset reports all-ones, meaning the period is unknown.
- Reset asserted mid-window discards the partial window. No `vel_valid` is produced for it.

## Timing
- All outputs are registered. `velocity`, `vel_sat` and `vel_valid` change on the rising edge that ends the terminal cycle; `vel_valid` is high for exactly that following cycle.
- First `vel_valid` after reset release with `ena` held high: on the `GATE_CYCLES`-th rising edge after release. Subsequent pulses repeat every `GATE_CYCLES` cycles.
- `period`/`per_valid` latency: 1 cycle after the `step` cycle.
- Steps on consecutive cycles are each counted. The minimum reported `period` is 1.
- `stalled` rises on the edge where the counter reaches all-ones and falls on the edge after the next step.

## Configuration
- `QEI_VEL_PERIOD_EN` defined: the period counter and FSM are built, and `period`, `per_valid` and `stalled` behave as specified.
- `QEI_VEL_PERIOD_EN` undefined: no period logic is built, and `period`, `per_valid` and `stalled` are tied to 0. Velocity behaviour is identical in both builds.

## Test plan
- Reset, `GATE_CYCLES`=100, no steps: all outputs 0. `vel_valid` pulses at cycles 100, 200, … after release, with `velocity` = 0 and `vel_sat` = 0.
- 10 forward steps in one window → `velocity` = +10. Next window with 7 forward then 3 backward steps → `velocity` = +4. A step placed on the terminal cycle counts in the closing window.
- `VEL_W`=6, 40 forward steps in one window → `velocity` = 31 and `vel_sat` = 1. The following empty window → 0 and `vel_sat` = 0. 40 backward steps → −32 and `vel_sat` = 1.
- `ena` low for 30 cycles mid-window carrying 5 steps (ignored), plus 6 enabled steps → `vel_valid` arrives 130 cycles after the window start with `velocity` = +6.
- `QEI_VEL_PERIOD_EN`, `PER_W`=8:
  - Steps every 25 cycles → first `period` = 255, thereafter `period` = 25, with `per_valid` one cycle after each step.
  - No steps for 255 cycles → `stalled` = 1; the next step clears it.
- Assert `rst_n` low mid-window with 12 steps accumulated, then release → no stale `vel_valid`. The first post-reset window reports only post-reset steps.
